// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider: per-channel divided clock level and
// period-start tick, with shadowed divisors applied only at period boundaries.
module clk_divider_prog #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS-1:0]       div_load,
  output logic [CHANNELS-1:0]       div_busy,
  output logic [CHANNELS-1:0]       load_err,
  output logic [CHANNELS-1:0]       clk_div,
  output logic [CHANNELS-1:0]       tick
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] half_d;
    logic [WIDTH-1:0] slice;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             wrap;

    assign slice = div_in[gi*WIDTH +: WIDTH];
    assign wrap  = (cnt_q == div_q - ONE);

    always_comb begin
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      half_d   = '0;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      err_d    = 1'b0;

      if (en[gi]) begin
        if (wrap) begin
          if (pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
          end
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        // High phase is ceil(D/2), taken from the divisor in force after a wrap.
        half_d = div_d - (div_d >> 1);
        clk_d  = (cnt_d < half_d);
        tick_d = (cnt_d == '0);
      end else begin
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
        // Park at the last count so re-enable wraps straight into a fresh period.
        cnt_d = div_d - ONE;
      end

      // A load on a wrap edge lands in the shadow after the wrap consumed the old one.
      if (div_load[gi]) begin
        if (slice < TWO) begin
          err_d = 1'b1;
        end else begin
          shadow_d = slice;
          pend_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        div_q    <= DEF_DIV;
        shadow_q <= DEF_DIV;
        pend_q   <= 1'b0;
        cnt_q    <= DEF_DIV - ONE;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        cnt_q    <= cnt_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
        err_q    <= err_d;
      end
    end

    assign div_busy[gi] = pend_q;
    assign load_err[gi] = err_q;
    assign clk_div[gi]  = clk_q;
    assign tick[gi]     = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed waveform checks on channel 0 plus a
// randomized run compared every cycle against a period-position model.
module tb_clk_divider_prog;
  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int DEF = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]     en = '0;
  logic [CH-1:0]     div_load = '0;
  logic [CH*W-1:0]   div_in = '0;
  logic [CH-1:0]     div_busy, load_err, clk_div, tick;

  clk_divider_prog #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
    .div_busy(div_busy), .load_err(load_err), .clk_div(clk_div), .tick(tick)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: active divisor, shadow, pending flag and position within the period.
  int  m_div [CH];
  int  m_sh  [CH];
  bit  m_pend[CH];
  int  m_pos [CH];
  bit  m_clk [CH];
  bit  m_tick[CH];
  bit  m_err [CH];
  bit  model_valid = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        m_div[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0; m_pos[c] = DEF - 1;
        m_clk[c] = 0; m_tick[c] = 0; m_err[c] = 0;
      end
      model_valid = 1'b1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        int sl;
        sl = int'(div_in[c*W +: W]);
        if (en[c]) begin
          if (m_pos[c] == m_div[c] - 1) begin
            if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
            m_pos[c] = 0;
          end else begin
            m_pos[c] = m_pos[c] + 1;
          end
          m_clk[c]  = (m_pos[c] < (m_div[c] + 1) / 2);
          m_tick[c] = (m_pos[c] == 0);
        end else begin
          if (m_pend[c]) begin m_div[c] = m_sh[c]; m_pend[c] = 0; end
          m_pos[c]  = m_div[c] - 1;
          m_clk[c]  = 0;
          m_tick[c] = 0;
        end
        m_err[c] = 0;
        if (div_load[c]) begin
          if (sl < 2) m_err[c] = 1;
          else begin m_sh[c] = sl; m_pend[c] = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("clk_div[%0d]", c), 32'(clk_div[c]), 32'(m_clk[c]));
        check($sformatf("tick[%0d]", c), 32'(tick[c]), 32'(m_tick[c]));
        check($sformatf("div_busy[%0d]", c), 32'(div_busy[c]), 32'(m_pend[c]));
        check($sformatf("load_err[%0d]", c), 32'(load_err[c]), 32'(m_err[c]));
      end
    end
  end

  logic [31:0] cap_clk, cap_tick, cap_busy, cap_err;

  task automatic clr();
    cap_clk = '0; cap_tick = '0; cap_busy = '0; cap_err = '0;
  endtask

  task automatic sample(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_clk  = {cap_clk[30:0], clk_div[0]};
      cap_tick = {cap_tick[30:0], tick[0]};
      cap_busy = {cap_busy[30:0], div_busy[0]};
      cap_err  = {cap_err[30:0], load_err[0]};
    end
  endtask

  task automatic setload(int ch, int val);
    div_load[ch] = 1'b1;
    div_in[ch*W +: W] = W'(val);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {28'b0, clk_div, tick}, 32'h0);
    check("reset_flags", {28'b0, div_busy, load_err}, 32'h0);

    // Default divisor 5: 3 high / 2 low, tick on first enabled edge
    en[0] = 1'b1;
    clr(); sample(10);
    check("d5_clk", cap_clk, 32'b1110011100);
    check("d5_tick", cap_tick, 32'b1000010000);

    // Load 4 at count 1: current period stays 5 long
    sample(2);
    setload(0, 4); clr(); sample(1); div_load[0] = 1'b0; sample(7);
    check("d4_clk", cap_clk, 32'b10011001);
    check("d4_busy", cap_busy, 32'b11100000);

    // Rejected loads of 0 and 1
    setload(0, 0); clr(); sample(1); setload(0, 1); sample(1); div_load[0] = 1'b0; sample(2);
    check("err_pulse", cap_err, 32'b1100);
    check("err_busy", cap_busy, 32'b0000);
    check("err_clk", cap_clk, 32'b1001);

    // Divisor 2
    setload(0, 2); clr(); sample(1); div_load[0] = 1'b0; sample(6);
    check("d2_clk", cap_clk, 32'b1001010);
    check("d2_tick", cap_tick, 32'b0001010);

    // Divisor 3, load coincides with a wrap and applies one period later
    setload(0, 3); clr(); sample(1); div_load[0] = 1'b0; sample(7);
    check("d3_clk", cap_clk, 32'b10110110);
    check("d3_busy", cap_busy, 32'b11000000);

    // Loads 7 then 6, the second on the wrap edge
    sample(1);
    setload(0, 7); clr(); sample(1); div_load[0] = 1'b0; sample(1);
    setload(0, 6); sample(1); div_load[0] = 1'b0; sample(13);
    check("d76_clk", cap_clk, 32'b1011110001110001);
    check("d76_busy", cap_busy, 32'b1111111110000000);

    // Disable with pending 3, then re-enable
    sample(1);
    setload(0, 3); sample(1); div_load[0] = 1'b0;
    en[0] = 1'b0; clr(); sample(1);
    check("dis_clk", 32'(clk_div[0]), 32'h0);
    check("dis_busy", 32'(div_busy[0]), 32'h0);
    sample(1);
    en[0] = 1'b1; clr(); sample(6);
    check("reen_clk", cap_clk, 32'b110110);
    check("reen_tick", cap_tick, 32'b100100);

    // Asynchronous reset mid-period discards a pending load
    en[1] = 1'b1;
    setload(0, 9); @(negedge clk); div_load[0] = 1'b0;
    sample(2);
    #5 rst = 1'b0;
    #1;
    check("arst_outputs", {28'b0, clk_div, tick}, 32'h0);
    check("arst_busy", {30'b0, div_busy}, 32'h0);
    @(negedge clk); rst = 1'b1;
    clr(); sample(10);
    check("post_rst_clk", cap_clk, 32'b1110011100);
    check("post_rst_busy", cap_busy, 32'h0);

    // Randomized traffic on both channels
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 99) < 3) en[c] = ~en[c];
        if ($urandom_range(0, 99) < 10) begin
          int r;
          r = int'($urandom_range(0, 9));
          if (r < 2) setload(c, r);
          else if (r < 8) setload(c, int'($urandom_range(2, 12)));
          else setload(c, int'($urandom_range(13, 400)));
        end else begin
          div_load[c] = 1'b0;
        end
      end
      if ($urandom_range(0, 1999) == 0) begin
        #4 rst = 1'b0;
        #3 rst = 1'b1;
      end
      @(negedge clk);
    end
    div_load = '0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
